// File: rtl/pipe_word_serializer.sv
// Pipe message serializer: buffers 96-bit {tag,meth,v} messages and emits them as 32-bit beats.
// Optional PIPE_SERIALIZER_HDR_EN adds a {beat count, sequence} header beat per message.
module pipe_word_serializer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          pipe_enq_ena,
    input  logic [95:0]   pipe_enq_v,
    output logic          pipe_enq_rdy,
    output logic          word_enq_ena,
    output logic [31:0]   word_enq_v,
    input  logic          word_enq_rdy,
    output logic [AW:0]   count
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_TAG  = 2'd0,
        ST_METH = 2'd1,
        ST_V    = 2'd2,
        ST_HDR  = 2'd3
    } beat_t;

`ifdef PIPE_SERIALIZER_HDR_EN
    localparam beat_t FIRST = ST_HDR;
`else
    localparam beat_t FIRST = ST_TAG;
`endif

    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    beat_t         beat;
    beat_t         beat_nxt;
    logic          pop;
    logic          do_enq;
    logic          not_empty;
    logic [95:0]   head;
    logic [31:0]   beat_word;
`ifdef PIPE_SERIALIZER_HDR_EN
    logic [15:0]   seq;
`endif

    assign not_empty    = (count != '0);
    assign pipe_enq_rdy = (count != FULL);
    assign do_enq       = pipe_enq_ena & pipe_enq_rdy;
    assign word_enq_ena = not_empty & word_enq_rdy;
    assign head         = mem[rd_ptr];
    assign word_enq_v   = not_empty ? beat_word : 32'h0;

    // Message storage; contents are only observed while count is non-zero.
    always_ff @(posedge CLK) begin
        if (do_enq) begin
            mem[wr_ptr] <= pipe_enq_v;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            beat   <= FIRST;
        end else begin
            beat <= beat_nxt;
            if (do_enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_enq, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef PIPE_SERIALIZER_HDR_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            seq <= '0;
        end else if (pop) begin
            seq <= seq + 16'd1;
        end
    end
`endif

    // Beat sequencer: advances only on an accepted beat; the last beat pops the head.
    always_comb begin
        beat_nxt  = beat;
        pop       = 1'b0;
        beat_word = 32'h0;
        case (beat)
            ST_TAG: begin
                beat_word = head[95:64];
                if (word_enq_ena) beat_nxt = ST_METH;
            end
            ST_METH: begin
                beat_word = head[63:32];
                if (word_enq_ena) beat_nxt = ST_V;
            end
            ST_V: begin
                beat_word = head[31:0];
                if (word_enq_ena) begin
                    beat_nxt = FIRST;
                    pop      = 1'b1;
                end
            end
            ST_HDR: begin
`ifdef PIPE_SERIALIZER_HDR_EN
                beat_word = {16'd3, seq};
                if (word_enq_ena) beat_nxt = ST_TAG;
`else
                beat_nxt  = FIRST;
`endif
            end
            default: beat_nxt = FIRST;
        endcase
    end

endmodule

// File: tb/tb_pipe_word_serializer.sv
// Self-checking bench for pipe_word_serializer: vector table plus hand sequences for reset, fill and wrap.
module tb_pipe_word_serializer;

`ifdef PIPE_SERIALIZER_HDR_EN
    localparam int BEATS = 4;
`else
    localparam int BEATS = 3;
`endif

    logic          clk;
    logic          rst_n;
    logic          pipe_enq_ena;
    logic [95:0]   pipe_enq_v;
    logic          pipe_enq_rdy;
    logic          word_enq_ena;
    logic [31:0]   word_enq_v;
    logic          word_enq_rdy;
    logic [2:0]    count;

    int n_tests = 0;
    int n_fail  = 0;
    int seq_m   = 0;

    pipe_word_serializer #(.DEPTH(4), .AW(2)) dut (
        .CLK          (clk),
        .nRST         (rst_n),
        .pipe_enq_ena (pipe_enq_ena),
        .pipe_enq_v   (pipe_enq_v),
        .pipe_enq_rdy (pipe_enq_rdy),
        .word_enq_ena (word_enq_ena),
        .word_enq_v   (word_enq_v),
        .word_enq_rdy (word_enq_rdy),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        enq;
        logic [95:0] data;
        logic        link;
        logic        ena;
        logic [31:0] word;
        logic [2:0]  cnt;
        logic        rdy;
    } vec_t;

    localparam logic [95:0] M1 = {32'h1, 32'hA5, 32'h1234};
    localparam logic [95:0] M2 = {32'h2, 32'hB6, 32'h5678};
    localparam logic [95:0] M3 = {32'h3, 32'hC, 32'hD};
    localparam logic [95:0] M4 = {32'h4, 32'hE, 32'hF};
    localparam logic [95:0] M5 = {32'h5, 32'h6, 32'h7};
    localparam logic [95:0] ZZ = 96'h0;

    function automatic logic [31:0] model_word(input logic [95:0] m, input int b, input int s);
`ifdef PIPE_SERIALIZER_HDR_EN
        case (b)
            0:       return {16'd3, 16'(s)};
            1:       return m[95:64];
            2:       return m[63:32];
            default: return m[31:0];
        endcase
`else
        if (s < 0) return 32'h0;
        case (b)
            0:       return m[95:64];
            1:       return m[63:32];
            default: return m[31:0];
        endcase
`endif
    endfunction

    task automatic cyc(input logic e, input logic [95:0] d, input logic l);
        @(negedge clk);
        pipe_enq_ena = e;
        pipe_enq_v   = d;
        word_enq_rdy = l;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic e, input logic [31:0] w,
                           input logic [2:0] c, input logic r);
        chk({nm, " ena"},   32'(word_enq_ena), 32'(e));
        chk({nm, " word"},  word_enq_v, w);
        chk({nm, " count"}, 32'(count), 32'(c));
        chk({nm, " rdy"},   32'(pipe_enq_rdy), 32'(r));
    endtask

    vec_t vecs [25];
    logic [95:0] fill [4];

    initial begin
        rst_n        = 1'b0;
        pipe_enq_ena = 1'b0;
        pipe_enq_v   = '0;
        word_enq_rdy = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_all("reset", 1'b0, 32'h0, 3'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef PIPE_SERIALIZER_HDR_EN
        // single message, 3-cycle stall in METH, enqueue+pop at count=2 with pointer wrap
        vecs[0]  = '{1'b1, M1, 1'b1, 1'b0, 32'h0,    3'd0, 1'b1};
        vecs[1]  = '{1'b0, ZZ, 1'b1, 1'b1, 32'h1,    3'd1, 1'b1};
        vecs[2]  = '{1'b0, ZZ, 1'b1, 1'b1, 32'hA5,   3'd1, 1'b1};
        vecs[3]  = '{1'b0, ZZ, 1'b1, 1'b1, 32'h1234, 3'd1, 1'b1};
        vecs[4]  = '{1'b0, ZZ, 1'b1, 1'b0, 32'h0,    3'd0, 1'b1};
        vecs[5]  = '{1'b1, M2, 1'b1, 1'b0, 32'h0,    3'd0, 1'b1};
        vecs[6]  = '{1'b0, ZZ, 1'b1, 1'b1, 32'h2,    3'd1, 1'b1};
        vecs[7]  = '{1'b0, ZZ, 1'b0, 1'b0, 32'hB6,   3'd1, 1'b1};
        vecs[8]  = '{1'b0, ZZ, 1'b0, 1'b0, 32'hB6,   3'd1, 1'b1};
        vecs[9]  = '{1'b0, ZZ, 1'b0, 1'b0, 32'hB6,   3'd1, 1'b1};
        vecs[10] = '{1'b0, ZZ, 1'b1, 1'b1, 32'hB6,   3'd1, 1'b1};
        vecs[11] = '{1'b0, ZZ, 1'b1, 1'b1, 32'h5678, 3'd1, 1'b1};
        vecs[12] = '{1'b0, ZZ, 1'b1, 1'b0, 32'h0,    3'd0, 1'b1};
        vecs[13] = '{1'b1, M3, 1'b0, 1'b0, 32'h0,    3'd0, 1'b1};
        vecs[14] = '{1'b1, M4, 1'b0, 1'b0, 32'h3,    3'd1, 1'b1};
        vecs[15] = '{1'b0, ZZ, 1'b1, 1'b1, 32'h3,    3'd2, 1'b1};
        vecs[16] = '{1'b0, ZZ, 1'b1, 1'b1, 32'hC,    3'd2, 1'b1};
        vecs[17] = '{1'b1, M5, 1'b1, 1'b1, 32'hD,    3'd2, 1'b1};
        vecs[18] = '{1'b0, ZZ, 1'b1, 1'b1, 32'h4,    3'd2, 1'b1};
        vecs[19] = '{1'b0, ZZ, 1'b1, 1'b1, 32'hE,    3'd2, 1'b1};
        vecs[20] = '{1'b0, ZZ, 1'b1, 1'b1, 32'hF,    3'd2, 1'b1};
        vecs[21] = '{1'b0, ZZ, 1'b1, 1'b1, 32'h5,    3'd1, 1'b1};
        vecs[22] = '{1'b0, ZZ, 1'b1, 1'b1, 32'h6,    3'd1, 1'b1};
        vecs[23] = '{1'b0, ZZ, 1'b1, 1'b1, 32'h7,    3'd1, 1'b1};
        vecs[24] = '{1'b0, ZZ, 1'b1, 1'b0, 32'h0,    3'd0, 1'b1};
        for (int i = 0; i < 25; i++) begin
            cyc(vecs[i].enq, vecs[i].data, vecs[i].link);
            chk_all($sformatf("vec%0d", i), vecs[i].ena, vecs[i].word, vecs[i].cnt, vecs[i].rdy);
        end
        seq_m = 5;
`else
        // single message with header beat
        cyc(1'b1, M1, 1'b1);
        chk_all("hdr idle", 1'b0, 32'h0, 3'd0, 1'b1);
        for (int b = 0; b < BEATS; b++) begin
            cyc(1'b0, ZZ, 1'b1);
            chk_all($sformatf("hdr b%0d", b), 1'b1, model_word(M1, b, seq_m), 3'd1, 1'b1);
        end
        seq_m++;
        cyc(1'b0, ZZ, 1'b1);
        chk_all("hdr drained", 1'b0, 32'h0, 3'd0, 1'b1);
`endif

        // Fill to DEPTH with the link stalled, then drain in FIFO order
        fill[0] = {32'h10, 32'h11, 32'h12};
        fill[1] = {32'h20, 32'h21, 32'h22};
        fill[2] = {32'h30, 32'h31, 32'h32};
        fill[3] = {32'h40, 32'h41, 32'h42};
        for (int k = 0; k < 4; k++) cyc(1'b1, fill[k], 1'b0);
        cyc(1'b0, ZZ, 1'b0);
        chk_all("full", 1'b0, model_word(fill[0], 0, seq_m), 3'd4, 1'b0);
        cyc(1'b1, {3{32'hDEAD}}, 1'b0);
        cyc(1'b0, ZZ, 1'b0);
        chk("full ignore count", 32'(count), 32'd4);
        for (int b = 0; b < 4 * BEATS; b++) begin
            cyc(1'b0, ZZ, 1'b1);
            chk_all($sformatf("drain%0d", b), 1'b1,
                    model_word(fill[b / BEATS], b % BEATS, (seq_m + b / BEATS) & 16'hFFFF),
                    3'(4 - b / BEATS), (b < BEATS) ? 1'b0 : 1'b1);
        end
        seq_m += 4;
        cyc(1'b0, ZZ, 1'b1);
        chk_all("drained", 1'b0, 32'h0, 3'd0, 1'b1);

        // Mid-message reset drops the partial message
        cyc(1'b1, M2, 1'b1);
        cyc(1'b1, M3, 1'b1);
        cyc(1'b0, ZZ, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all("mid reset", 1'b0, 32'h0, 3'd0, 1'b1);
        seq_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, M4, 1'b1);
        chk_all("post reset idle", 1'b0, 32'h0, 3'd0, 1'b1);
        for (int b = 0; b < BEATS; b++) begin
            cyc(1'b0, ZZ, 1'b1);
            chk_all($sformatf("post reset b%0d", b), 1'b1, model_word(M4, b, seq_m), 3'd1, 1'b1);
        end
        cyc(1'b0, ZZ, 1'b1);
        chk_all("post reset drained", 1'b0, 32'h0, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
